latch_bist: RTL and testbench

Built-in self-test sequencer that drives the D-latch data/enable interface and checks the latch output. It generates pseudo-random D/EN vectors from an 8-bit LFSR, keeps a golden model of the expected Q, samples the returned Q through a 2-flop synchronizer, and counts mismatches. It sits inside the Tiny Tapeout user project between the dedicated I/O and the latch. On silicon it does the job the cocotb bench does in simulation: it drives D/EN and checks Q.

---
 rtl/latch_bist_pkg.sv | 21 ++
 rtl/latch_bist_if.sv | 21 ++
 rtl/latch_bist_sync2.sv | 19 +
 rtl/latch_bist.sv | 90 +++++++++
 tb/tb_latch_bist.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/latch_bist_pkg.sv
// rtl/latch_bist_pkg.sv - shared types, constants and LFSR step for the latch BIST
package latch_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_t;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [7:0] ERR_MAX      = 8'hFF;

    // Galois right shift, x^8+x^6+x^5+x^4+1; a nonzero state never reaches zero
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/latch_bist_if.sv
// rtl/latch_bist_if.sv - run control, latch drive and result bundle of the latch BIST
interface latch_bist_if;
    logic       start;
    logic       q_in;
    logic       d_out;
    logic       en_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;

    modport master (
        input  start, q_in,
        output d_out, en_out, busy, done, pass, err_count
    );

    modport slave (
        output start, q_in,
        input  d_out, en_out, busy, done, pass, err_count
    );
endinterface

// File: rtl/latch_bist_sync2.sv
// rtl/latch_bist_sync2.sv - 1-bit two-flop synchronizer, async active-high reset to 0
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/latch_bist.sv
// rtl/latch_bist.sv - LFSR-driven D-latch self-test sequencer with golden Q model
module latch_bist
    import latch_bist_pkg::*;
#(
    parameter int         NUM_VEC = 16,
    parameter int         SETTLE  = 4,
    parameter logic [7:0] SEED    = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst,
    latch_bist_if.master  bus
);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [15:0] VEC_LAST    = 16'(NUM_VEC - 1);

    bist_state_t state;
    logic [7:0]  lfsr;
    logic [15:0] vec;
    logic [7:0]  wcnt;
    logic [7:0]  err_count;
    logic        d_q;
    logic        en_q;
    logic        exp_q;
    logic        q_s;
    logic        en_next;

    sync2 u_q_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.q_in),
        .q   (q_s)
    );

    // vector 0 always opens the latch so the golden model starts defined
    assign en_next = lfsr[1] | (vec == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lfsr      <= 8'h00;
            vec       <= 16'd0;
            wcnt      <= 8'd0;
            err_count <= 8'd0;
            d_q       <= 1'b0;
            en_q      <= 1'b0;
            exp_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state     <= ST_APPLY;
                        lfsr      <= SEED;
                        vec       <= 16'd0;
                        err_count <= 8'd0;
                    end
                end
                ST_APPLY: begin
                    d_q   <= lfsr[0];
                    en_q  <= en_next;
                    if (en_next)
                        exp_q <= lfsr[0];
                    wcnt  <= 8'd0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    wcnt <= wcnt + 8'd1;
                    if (wcnt == SETTLE_LAST)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if ((q_s != exp_q) && (err_count != ERR_MAX))
                        err_count <= err_count + 8'd1;
                    // closing the latch here keeps D changes from racing an open latch
                    en_q  <= 1'b0;
                    lfsr  <= lfsr_step(lfsr);
                    vec   <= vec + 16'd1;
                    state <= (vec == VEC_LAST) ? ST_DONE : ST_APPLY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.d_out     = d_q;
    assign bus.en_out    = en_q;
    assign bus.busy      = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign bus.done      = (state == ST_DONE);
    assign bus.pass      = (state == ST_DONE) && (err_count == 8'd0);
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_latch_bist.sv
// tb/tb_latch_bist.sv - scoreboard bench for latch_bist with behavioural latch models
module tb_latch_bist;
    typedef struct {
        int     err;
        int     pass;
        longint cyc;
    } exp_t;

    logic   clk;
    logic   rst;
    longint cyc;
    int     checks;
    int     errors;
    int     mode;
    logic   q1;
    logic   q2;
    logic   d1_prev;
    logic   d2_prev;
    exp_t   sb1[$];
    exp_t   sb2[$];

    latch_bist_if bus1 ();
    latch_bist_if bus2 ();

    latch_bist u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    latch_bist #(.NUM_VEC(300)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always_latch if (bus1.en_out) q1 <= bus1.d_out;
    always_latch if (bus2.en_out) q2 <= bus2.d_out;

    // mode 0: good latch, 1: inverted Q, 2: Q stuck at 0
    assign bus1.q_in = (mode == 0) ? q1 : (mode == 1) ? ~q1 : 1'b0;
    assign bus2.q_in = ~q2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int stuck0_errors(input logic [7:0] seed, input int n);
        logic [7:0] s;
        logic       e;
        int         c;
        s = seed;
        e = 1'b0;
        c = 0;
        for (int v = 0; v < n; v++) begin
            if (s[1] || v == 0) e = s[0];
            if (e && c < 255) c++;
            s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
        end
        return c;
    endfunction

    task automatic pulse1(output longint sample);
        @(negedge clk);
        bus1.start = 1'b1;
        sample = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    task automatic wait_sb(input int which, input int limit);
        int n;
        n = 0;
        while (((which == 1) ? sb1.size() : sb2.size()) != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (((which == 1) ? sb1.size() : sb2.size()) != 0) begin
            errors++;
            $display("FAIL done_timeout dut%0d: no done within %0d cycles", which, limit);
        end
    endtask

    initial begin
        d1_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.done && !d1_prev) begin
                if (sb1.size() == 0) begin
                    check("unexpected_done1", 1, 0);
                end else begin
                    exp_t e;
                    e = sb1.pop_front();
                    check("err_count", int'(bus1.err_count), e.err);
                    check("pass", int'(bus1.pass), e.pass);
                    check("done_latency", int'(cyc), int'(e.cyc));
                end
            end
            d1_prev = bus1.done;
        end
    end

    initial begin
        d2_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2.done && !d2_prev) begin
                if (sb2.size() == 0) begin
                    check("unexpected_done2", 1, 0);
                end else begin
                    exp_t e;
                    e = sb2.pop_front();
                    check("sat_err_count", int'(bus2.err_count), e.err);
                    check("sat_pass", int'(bus2.pass), e.pass);
                    check("sat_done_latency", int'(cyc), int'(e.cyc));
                end
            end
            d2_prev = bus2.done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        longint s;
        longint dummy;
        int     n0;
        checks     = 0;
        errors     = 0;
        mode       = 0;
        rst        = 1'b1;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus1.busy), 0);
        check("rst_done", int'(bus1.done), 0);
        check("rst_pass", int'(bus1.pass), 0);
        check("rst_err", int'(bus1.err_count), 0);
        check("rst_d", int'(bus1.d_out), 0);
        check("rst_en", int'(bus1.en_out), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // good latch, defaults
        mode = 0;
        pulse1(s);
        sb1.push_back('{0, 1, s + 96});
        check("busy_after_start", int'(bus1.busy), 1);
        @(negedge clk);
        check("en_first_settle", int'(bus1.en_out), 1);
        check("done_low_running", int'(bus1.done), 0);
        wait_sb(1, 200);

        // inverted Q
        mode = 1;
        pulse1(s);
        sb1.push_back('{16, 0, s + 96});
        wait_sb(1, 200);

        // Q stuck at 0
        mode = 2;
        n0 = stuck0_errors(8'hA5, 16);
        pulse1(s);
        sb1.push_back('{n0, (n0 == 0) ? 1 : 0, s + 96});
        wait_sb(1, 200);

        // start while busy is ignored, then restart from DONE clears err_count
        mode = 1;
        pulse1(s);
        sb1.push_back('{16, 0, s + 96});
        repeat (37) @(negedge clk);
        pulse1(dummy);
        wait_sb(1, 200);
        mode = 0;
        pulse1(s);
        sb1.push_back('{0, 1, s + 96});
        check("restart_err_cleared", int'(bus1.err_count), 0);
        check("restart_busy", int'(bus1.busy), 1);
        wait_sb(1, 200);

        // reset in SETTLE of vector 5
        mode = 1;
        pulse1(s);
        while (cyc < s + 32) @(negedge clk);
        check("pre_rst_err", int'(bus1.err_count), 5);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(bus1.busy), 0);
        check("mid_rst_done", int'(bus1.done), 0);
        check("mid_rst_pass", int'(bus1.pass), 0);
        check("mid_rst_err", int'(bus1.err_count), 0);
        check("mid_rst_d", int'(bus1.d_out), 0);
        check("mid_rst_en", int'(bus1.en_out), 0);
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        pulse1(s);
        sb1.push_back('{0, 1, s + 96});
        wait_sb(1, 200);

        // saturation with 300 vectors on the inverted-latch instance
        @(negedge clk);
        bus2.start = 1'b1;
        sb2.push_back('{255, 0, cyc + 1 + 1800});
        @(negedge clk);
        bus2.start = 1'b0;
        wait_sb(2, 2000);
        repeat (5) @(negedge clk);
        check("sat_hold", int'(bus2.err_count), 255);
        check("sat_done_hold", int'(bus2.done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
